// File: rtl/bp_mmio_word_splitter.sv
// bp_mmio_word_splitter
// Bridges BlackParrot uncached I/O commands onto a 32-bit MMIO word port.
// 64-bit accesses become two in-order word accesses (low then high), narrower
// accesses pass through as one word, and word responses are merged back into
// one response per original command, returned in command order.
module bp_mmio_word_splitter #(
    parameter int paddr_width_p     = 40,
    parameter int tag_width_p       = 8,
    parameter int max_outstanding_p = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     cmd_v_i,
    output logic                     cmd_ready_o,
    input  logic [paddr_width_p-1:0] cmd_addr_i,
    input  logic [1:0]               cmd_size_i,
    input  logic                     cmd_we_i,
    input  logic [63:0]              cmd_data_i,
    input  logic [tag_width_p-1:0]   cmd_tag_i,

    output logic                     word_v_o,
    input  logic                     word_ready_i,
    output logic [paddr_width_p-1:0] word_addr_o,
    output logic [1:0]               word_size_o,
    output logic                     word_we_o,
    output logic [31:0]              word_data_o,

    input  logic                     word_resp_v_i,
    output logic                     word_resp_yumi_o,
    input  logic [31:0]              word_resp_data_i,

    output logic                     resp_v_o,
    input  logic                     resp_ready_i,
    output logic [63:0]              resp_data_o,
    output logic                     resp_we_o,
    output logic [1:0]               resp_size_o,
    output logic [tag_width_p-1:0]   resp_tag_o
);

    localparam int ptr_w_lp  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int cnt_w_lp  = $clog2(max_outstanding_p + 1);
    localparam int meta_w_lp = tag_width_p + 4;

    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(max_outstanding_p - 1);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(max_outstanding_p);

    typedef enum logic [1:0] {e_idle, e_send_lo, e_send_hi} cmd_state_e;
    typedef enum logic {e_rlo, e_rhi} resp_state_e;

    cmd_state_e  cmd_state_r, cmd_state_n;
    resp_state_e resp_state_r, resp_state_n;

    // Accepted command, held while its word(s) are sent
    logic [paddr_width_p-1:0] cmd_addr_p0;
    logic [1:0]               cmd_size_p0;
    logic                     cmd_we_p0;
    logic [63:0]              cmd_data_p0;
    logic                     cmd_split_p0;

    // Metadata FIFO: {tag, size, we, split} per outstanding command
    logic [meta_w_lp-1:0] meta_mem [max_outstanding_p];
    logic [ptr_w_lp-1:0]  wr_ptr_r, rd_ptr_r;
    logic [cnt_w_lp-1:0]  count_r;
    logic                 fifo_full, fifo_empty;
    logic                 push, pop;

    logic [tag_width_p-1:0] head_tag;
    logic [1:0]             head_size;
    logic                   head_we;
    logic                   head_split;

    // Low half of a split response, waiting for its high half
    logic [31:0] lo_r;
    logic        lo_capture;

    assign fifo_full    = (count_r == full_cnt_lp);
    assign fifo_empty   = (count_r == '0);
    assign push         = cmd_v_i & cmd_ready_o;
    assign cmd_split_p0 = (cmd_size_p0 == 2'd3);

    assign {head_tag, head_size, head_we, head_split} = meta_mem[rd_ptr_r];

    // Command FSM state register
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cmd_state_r <= e_idle;
        end else begin
            cmd_state_r <= cmd_state_n;
        end
    end

    // Capture the command on upstream handshake; only read while not idle
    always_ff @(posedge clk_i) begin
        if (push) begin
            cmd_addr_p0 <= cmd_addr_i;
            cmd_size_p0 <= cmd_size_i;
            cmd_we_p0   <= cmd_we_i;
            cmd_data_p0 <= cmd_data_i;
        end
    end

    // Command FSM: upstream ready, word command generation, next state
    always_comb begin
        cmd_state_n = cmd_state_r;
        cmd_ready_o = 1'b0;
        word_v_o    = 1'b0;
        word_addr_o = '0;
        word_size_o = 2'd0;
        word_we_o   = 1'b0;
        word_data_o = 32'd0;
        case (cmd_state_r)
            e_idle: begin
                cmd_ready_o = ~fifo_full;
                if (cmd_v_i && !fifo_full) begin
                    cmd_state_n = e_send_lo;
                end
            end
            e_send_lo: begin
                word_v_o    = 1'b1;
                word_we_o   = cmd_we_p0;
                word_data_o = cmd_data_p0[31:0];
                if (cmd_split_p0) begin
                    word_addr_o = {cmd_addr_p0[paddr_width_p-1:3], 3'b000};
                    word_size_o = 2'd2;
                end else begin
                    word_addr_o = cmd_addr_p0;
                    word_size_o = cmd_size_p0;
                end
                if (word_ready_i) begin
                    cmd_state_n = cmd_split_p0 ? e_send_hi : e_idle;
                end
            end
            e_send_hi: begin
                word_v_o    = 1'b1;
                word_we_o   = cmd_we_p0;
                word_addr_o = {cmd_addr_p0[paddr_width_p-1:3], 3'b100};
                word_size_o = 2'd2;
                word_data_o = cmd_data_p0[63:32];
                if (word_ready_i) begin
                    cmd_state_n = e_idle;
                end
            end
            default: begin
                cmd_state_n = e_idle;
            end
        endcase
    end

    // Metadata FIFO storage; emptiness is tracked by count_r alone
    always_ff @(posedge clk_i) begin
        if (push) begin
            meta_mem[wr_ptr_r] <= {cmd_tag_i, cmd_size_i, cmd_we_i, (cmd_size_i == 2'd3)};
        end
    end

    // Metadata FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + ptr_w_lp'(1);
            end
            if (pop) begin
                rd_ptr_r <= (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + ptr_w_lp'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + cnt_w_lp'(1);
                2'b01:   count_r <= count_r - cnt_w_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Response FSM state register and low-half capture
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            resp_state_r <= e_rlo;
            lo_r         <= 32'd0;
        end else begin
            resp_state_r <= resp_state_n;
            if (lo_capture) begin
                lo_r <= word_resp_data_i;
            end
        end
    end

    // Response FSM: merge word responses for the command at the FIFO head
    always_comb begin
        logic take;
        take             = 1'b0;
        resp_state_n     = resp_state_r;
        resp_v_o         = 1'b0;
        resp_data_o      = 64'd0;
        resp_we_o        = 1'b0;
        resp_size_o      = 2'd0;
        resp_tag_o       = '0;
        word_resp_yumi_o = 1'b0;
        pop              = 1'b0;
        lo_capture       = 1'b0;
        if (!fifo_empty) begin
            resp_we_o   = head_we;
            resp_size_o = head_size;
            resp_tag_o  = head_tag;
            if (resp_state_r == e_rhi) begin
                resp_v_o         = word_resp_v_i;
                resp_data_o      = {word_resp_data_i, lo_r};
                take             = word_resp_v_i & resp_ready_i;
                word_resp_yumi_o = take;
                pop              = take;
                if (take) begin
                    resp_state_n = e_rlo;
                end
            end else if (head_split) begin
                word_resp_yumi_o = word_resp_v_i;
                lo_capture       = word_resp_v_i;
                if (word_resp_v_i) begin
                    resp_state_n = e_rhi;
                end
            end else begin
                resp_v_o         = word_resp_v_i;
                resp_data_o      = {32'd0, word_resp_data_i};
                take             = word_resp_v_i & resp_ready_i;
                word_resp_yumi_o = take;
                pop              = take;
            end
        end
    end

    // A word response with nothing outstanding indicates a broken bridge
    a_resp_without_cmd: assert property (@(posedge clk_i) disable iff (!reset_i)
        !(word_resp_v_i && fifo_empty));

endmodule

// File: tb/tb_bp_mmio_word_splitter.sv
// Directed bench for bp_mmio_word_splitter: a vector table of single commands
// plus hand-written sequences for stalls, backpressure, FIFO full and reset.
`timescale 1ns/1ps
module tb_bp_mmio_word_splitter;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        cmd_v_i = 1'b0;
    logic        cmd_ready_o;
    logic [39:0] cmd_addr_i = '0;
    logic [1:0]  cmd_size_i = '0;
    logic        cmd_we_i = 1'b0;
    logic [63:0] cmd_data_i = '0;
    logic [7:0]  cmd_tag_i = '0;
    logic        word_v_o;
    logic        word_ready_i = 1'b0;
    logic [39:0] word_addr_o;
    logic [1:0]  word_size_o;
    logic        word_we_o;
    logic [31:0] word_data_o;
    logic        word_resp_v_i = 1'b0;
    logic        word_resp_yumi_o;
    logic [31:0] word_resp_data_i = '0;
    logic        resp_v_o;
    logic        resp_ready_i = 1'b0;
    logic [63:0] resp_data_o;
    logic        resp_we_o;
    logic [1:0]  resp_size_o;
    logic [7:0]  resp_tag_o;

    int checks = 0;
    int errors = 0;
    int word_hs = 0;
    int yumi_cnt = 0;

    bp_mmio_word_splitter #(
        .paddr_width_p(40), .tag_width_p(8), .max_outstanding_p(4)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
        .cmd_size_i(cmd_size_i), .cmd_we_i(cmd_we_i), .cmd_data_i(cmd_data_i),
        .cmd_tag_i(cmd_tag_i),
        .word_v_o(word_v_o), .word_ready_i(word_ready_i), .word_addr_o(word_addr_o),
        .word_size_o(word_size_o), .word_we_o(word_we_o), .word_data_o(word_data_o),
        .word_resp_v_i(word_resp_v_i), .word_resp_yumi_o(word_resp_yumi_o),
        .word_resp_data_i(word_resp_data_i),
        .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
        .resp_we_o(resp_we_o), .resp_size_o(resp_size_o), .resp_tag_o(resp_tag_o)
    );

    always #5 clk_i = ~clk_i;

    // Handshake counters observed at the active edge
    always @(posedge clk_i) begin
        if (reset_i && word_v_o && word_ready_i) word_hs <= word_hs + 1;
        if (reset_i && word_resp_yumi_o) yumi_cnt <= yumi_cnt + 1;
    end

    typedef struct {
        logic [39:0] addr;
        logic [1:0]  size;
        logic        we;
        logic [63:0] data;
        logic [7:0]  tag;
        logic [31:0] rlo;
        logic [31:0] rhi;
        logic        split;
        logic [39:0] exp_alo;
        logic [1:0]  exp_slo;
        logic [31:0] exp_dlo;
        logic [39:0] exp_ahi;
        logic [31:0] exp_dhi;
        logic [63:0] exp_resp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Present a command and wait (bounded) for it to be accepted
    task automatic issue(input logic [39:0] a, input logic [1:0] s, input logic w,
                         input logic [63:0] d, input logic [7:0] t);
        int n;
        @(negedge clk_i);
        cmd_addr_i = a; cmd_size_i = s; cmd_we_i = w; cmd_data_i = d; cmd_tag_i = t;
        cmd_v_i = 1'b1;
        #1;
        n = 0;
        while (!cmd_ready_o && n < 50) begin
            @(negedge clk_i); #1;
            n++;
        end
        check("issue_accept", cmd_ready_o, 1'b1);
        @(posedge clk_i); #1;
        cmd_v_i = 1'b0;
    endtask

    // Return the word response(s) for the head command and check the merge
    task automatic drain(input string nm, input logic split, input logic [31:0] lo,
                         input logic [31:0] hi, input logic [7:0] tag, input logic we,
                         input logic [1:0] size, input logic [63:0] exp);
        @(negedge clk_i);
        word_resp_v_i = 1'b1; word_resp_data_i = lo; resp_ready_i = 1'b1;
        #1;
        if (split) begin
            check({nm, " lo resp_v"}, resp_v_o, 1'b0);
            check({nm, " lo yumi"}, word_resp_yumi_o, 1'b1);
            @(negedge clk_i);
            word_resp_data_i = hi;
            #1;
        end
        check({nm, " resp_v"}, resp_v_o, 1'b1);
        check({nm, " resp_data"}, resp_data_o, exp);
        check({nm, " resp_tag"}, resp_tag_o, tag);
        check({nm, " resp_we"}, resp_we_o, we);
        check({nm, " resp_size"}, resp_size_o, size);
        check({nm, " yumi"}, word_resp_yumi_o, 1'b1);
        @(posedge clk_i); #1;
        word_resp_v_i = 1'b0; word_resp_data_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        vecs[0] = '{40'h1000, 2'd2, 1'b1, 64'hAABBCCDD_11223344, 8'h11, 32'hDEADBEEF, 32'h0, 1'b0,
                    40'h1000, 2'd2, 32'h11223344, 40'h0, 32'h0, 64'h00000000_DEADBEEF};
        vecs[1] = '{40'h2004, 2'd3, 1'b0, 64'h0, 8'h22, 32'h11111111, 32'h22222222, 1'b1,
                    40'h2000, 2'd2, 32'h0, 40'h2004, 32'h0, 64'h22222222_11111111};
        vecs[2] = '{40'h3003, 2'd0, 1'b1, 64'h12345678_9ABCDEEF, 8'h33, 32'h000000AB, 32'h0, 1'b0,
                    40'h3003, 2'd0, 32'h9ABCDEEF, 40'h0, 32'h0, 64'h00000000_000000AB};
        vecs[3] = '{40'h4002, 2'd1, 1'b0, 64'h0, 8'h44, 32'hFFFF8765, 32'h0, 1'b0,
                    40'h4002, 2'd1, 32'h0, 40'h0, 32'h0, 64'h00000000_FFFF8765};
        vecs[4] = '{40'h5000, 2'd3, 1'b1, 64'h01020304_05060708, 8'h55, 32'hCAFEF00D, 32'h0BADF00D, 1'b1,
                    40'h5000, 2'd2, 32'h05060708, 40'h5004, 32'h01020304, 64'h0BADF00D_CAFEF00D};
        vecs[5] = '{40'h600F, 2'd3, 1'b1, 64'hFFFFFFFF_00000000, 8'h5F, 32'h00000001, 32'h80000000, 1'b1,
                    40'h6008, 2'd2, 32'h00000000, 40'h600C, 32'hFFFFFFFF, 64'h80000000_00000001};

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        check("rst cmd_ready", cmd_ready_o, 1'b1);
        check("rst word_v", word_v_o, 1'b0);
        check("rst yumi", word_resp_yumi_o, 1'b0);
        check("rst resp_v", resp_v_o, 1'b0);
        check("rst resp_data", resp_data_o, 64'h0);
        check("rst word_addr", word_addr_o, 40'h0);
        check("rst word_data", word_data_o, 32'h0);

        // Table of single commands, each issued, sent and answered in isolation
        for (int i = 0; i < 6; i++) begin
            word_ready_i = 1'b0;
            issue(vecs[i].addr, vecs[i].size, vecs[i].we, vecs[i].data, vecs[i].tag);
            @(negedge clk_i);
            word_ready_i = 1'b1;
            #1;
            check($sformatf("v%0d lo word_v", i), word_v_o, 1'b1);
            check($sformatf("v%0d lo addr", i), word_addr_o, vecs[i].exp_alo);
            check($sformatf("v%0d lo size", i), word_size_o, vecs[i].exp_slo);
            check($sformatf("v%0d lo we", i), word_we_o, vecs[i].we);
            check($sformatf("v%0d lo data", i), word_data_o, vecs[i].exp_dlo);
            check($sformatf("v%0d busy cmd_ready", i), cmd_ready_o, 1'b0);
            @(posedge clk_i); #1;
            if (vecs[i].split) begin
                @(negedge clk_i); #1;
                check($sformatf("v%0d hi word_v", i), word_v_o, 1'b1);
                check($sformatf("v%0d hi addr", i), word_addr_o, vecs[i].exp_ahi);
                check($sformatf("v%0d hi size", i), word_size_o, 2'd2);
                check($sformatf("v%0d hi data", i), word_data_o, vecs[i].exp_dhi);
                @(posedge clk_i); #1;
            end
            word_ready_i = 1'b0;
            @(negedge clk_i); #1;
            check($sformatf("v%0d done word_v", i), word_v_o, 1'b0);
            check($sformatf("v%0d done cmd_ready", i), cmd_ready_o, 1'b1);
            drain($sformatf("v%0d", i), vecs[i].split, vecs[i].rlo, vecs[i].rhi, vecs[i].tag,
                  vecs[i].we, vecs[i].size, vecs[i].exp_resp);
        end

        // Stall the high word for 5 cycles
        base = word_hs;
        word_ready_i = 1'b0;
        issue(40'h7000, 2'd3, 1'b1, 64'h89ABCDEF_01234567, 8'h66);
        @(negedge clk_i);
        word_ready_i = 1'b1;
        #1;
        check("stall lo addr", word_addr_o, 40'h7000);
        @(posedge clk_i); #1;
        word_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i); #1;
            check($sformatf("stall%0d word_v", k), word_v_o, 1'b1);
            check($sformatf("stall%0d addr", k), word_addr_o, 40'h7004);
            check($sformatf("stall%0d data", k), word_data_o, 32'h89ABCDEF);
            check($sformatf("stall%0d cmd_ready", k), cmd_ready_o, 1'b0);
        end
        @(negedge clk_i);
        word_ready_i = 1'b1;
        @(posedge clk_i); #1;
        word_ready_i = 1'b0;
        @(negedge clk_i); #1;
        check("stall done word_v", word_v_o, 1'b0);
        check("stall word handshakes", word_hs - base, 2);
        drain("stall", 1'b1, 32'h1, 32'h2, 8'h66, 1'b1, 2'd3, 64'h00000002_00000001);

        // Fill the metadata FIFO with four loads, fifth waits for a pop
        word_ready_i = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            issue(40'h8000 + 40'(4 * t), 2'd2, 1'b0, 64'h0, 8'(t));
        end
        repeat (2) @(negedge clk_i);
        #1;
        check("full cmd_ready", cmd_ready_o, 1'b0);
        cmd_addr_i = 40'h8100; cmd_size_i = 2'd2; cmd_we_i = 1'b0; cmd_tag_i = 8'd5;
        cmd_v_i = 1'b1;
        @(negedge clk_i);
        word_resp_v_i = 1'b1; word_resp_data_i = 32'h100; resp_ready_i = 1'b1;
        #1;
        check("full pop cmd_ready", cmd_ready_o, 1'b0);
        check("full first tag", resp_tag_o, 8'd1);
        check("full first data", resp_data_o, 64'h100);
        @(posedge clk_i); #1;
        word_resp_v_i = 1'b0;
        @(negedge clk_i); #1;
        check("full after pop cmd_ready", cmd_ready_o, 1'b1);
        @(posedge clk_i); #1;
        cmd_v_i = 1'b0;
        for (int t = 2; t <= 5; t++) begin
            drain($sformatf("full t%0d", t), 1'b0, 32'(t), 32'h0, 8'(t), 1'b0, 2'd2, 64'(t));
        end

        // Upstream backpressure on a merged response; tags 1,2,3 in order
        issue(40'h9000, 2'd3, 1'b0, 64'h0, 8'd1);
        issue(40'h9010, 2'd2, 1'b0, 64'h0, 8'd2);
        issue(40'h9020, 2'd3, 1'b0, 64'h0, 8'd3);
        repeat (3) @(posedge clk_i);
        base = yumi_cnt;
        @(negedge clk_i);
        resp_ready_i = 1'b0; word_resp_v_i = 1'b1; word_resp_data_i = 32'hA0;
        #1;
        check("bp lo yumi", word_resp_yumi_o, 1'b1);
        check("bp lo resp_v", resp_v_o, 1'b0);
        @(negedge clk_i);
        word_resp_data_i = 32'hA1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d resp_v", k), resp_v_o, 1'b1);
            check($sformatf("bp%0d yumi", k), word_resp_yumi_o, 1'b0);
            check($sformatf("bp%0d data", k), resp_data_o, 64'h000000A1_000000A0);
            check($sformatf("bp%0d tag", k), resp_tag_o, 8'd1);
            @(negedge clk_i); #1;
        end
        check("bp yumi count", yumi_cnt - base, 1);
        resp_ready_i = 1'b1;
        #1;
        check("bp release yumi", word_resp_yumi_o, 1'b1);
        @(posedge clk_i); #1;
        word_resp_v_i = 1'b0;
        drain("bp t2", 1'b0, 32'hB0, 32'h0, 8'd2, 1'b0, 2'd2, 64'hB0);
        drain("bp t3", 1'b1, 32'hC0, 32'hC1, 8'd3, 1'b0, 2'd3, 64'h000000C1_000000C0);

        // Reset while the high word is pending
        word_ready_i = 1'b0;
        issue(40'hA000, 2'd3, 1'b0, 64'h0, 8'h77);
        @(negedge clk_i);
        word_ready_i = 1'b1;
        @(posedge clk_i); #1;
        word_ready_i = 1'b0;
        @(negedge clk_i); #1;
        check("rsthi word_v", word_v_o, 1'b1);
        check("rsthi addr", word_addr_o, 40'hA004);
        reset_i = 1'b0;
        @(negedge clk_i); #1;
        check("rsthi after word_v", word_v_o, 1'b0);
        check("rsthi after resp_v", resp_v_o, 1'b0);
        check("rsthi after yumi", word_resp_yumi_o, 1'b0);
        reset_i = 1'b1;
        #1;
        check("rsthi release cmd_ready", cmd_ready_o, 1'b1);
        word_ready_i = 1'b1;
        issue(40'hB000, 2'd2, 1'b0, 64'h0, 8'h78);
        drain("rsthi new", 1'b0, 32'h5A, 32'h0, 8'h78, 1'b0, 2'd2, 64'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
